// File: rtl/fetch_queue.sv
// fetch_queue: PC-to-decode fetch buffer with one outstanding imem read and branch flush
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [WIDTH-1:0] addr;
  logic drop;
  logic [WIDTH-1:0] mem_pc [DEPTH];
  logic [WIDTH-1:0] mem_in [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic push, pop;
  assign pc_ready = state == IDLE && !flush && count < FULL;
  assign push = state == WAIT && imem_rvalid && !drop && !flush;
  assign instr_valid = count != '0;
  assign pop = instr_valid && instr_ready && !flush;
  assign imem_req = state == WAIT;
  assign imem_addr = addr;
  assign instr = mem_in[rp];
  assign instr_pc = mem_pc[rp];
  // request FSM: one outstanding read; a flush while waiting poisons the pending response
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      drop <= 1'b0;
    end else if (state == IDLE) begin
      if (pc_valid && pc_ready) begin
        state <= WAIT;
        addr <= pc_in;
      end
    end else if (imem_rvalid) begin
      state <= IDLE;
      drop <= 1'b0;
    end else if (flush) drop <= 1'b1;
  // FIFO bookkeeping; flush empties it regardless of push/pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // entry storage, left unreset since it is only read while count is nonzero
  always_ff @(posedge clk)
    if (push) begin
      mem_pc[wp] <= addr;
      mem_in[wp] <= imem_rdata;
    end
endmodule
